// File: rtl/matrix_loader_hps.sv
// matrix_loader_hps: collects two square byte matrices (2x2..5x5) from a
// stream of 32-bit HPS words and presents them, packed, to a downstream stage.
module matrix_loader_hps #(
  parameter int DATA_W = 32
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [1:0]         size,
  input  logic [DATA_W-1:0]  in_data,
  input  logic               in_valid,
  output logic               in_ready,
  output logic [199:0]       matrix1_out,
  output logic [199:0]       matrix2_out,
  output logic [1:0]         size_out,
  output logic               matrix_valid,
  input  logic               consume,
  output logic               busy
);

  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    LOAD_M1 = 2'b01,
    LOAD_M2 = 2'b10,
    DONE    = 2'b11
  } state_t;

  state_t         state_r, state_next_s;
  logic [2:0]     count_r, count_next_s;
  logic [1:0]     size_next_s;
  logic [199:0]   m1_next_s, m2_next_s;
  logic [4:0]     n_elem_s;
  logic [2:0]     last_word_s;

  // Write the four bytes of word k into elements 4k..4k+3, dropping any with index >= n.
  function automatic logic [199:0] merge_word(input logic [199:0] mat,
                                              input logic [31:0]  word,
                                              input logic [2:0]   k,
                                              input logic [4:0]   n);
    logic [199:0] res;
    logic [4:0]   ei;
    res = mat;
    for (int e = 0; e < 25; e++) begin
      ei = 5'(e);
      if ((ei[4:2] == k) && (ei < n)) begin
        res[199-8*e -: 8] = word[31-8*(e%4) -: 8];
      end
    end
    return res;
  endfunction

  // Element count and final word index for the latched size code.
  always_comb begin
    n_elem_s    = 5'd4;
    last_word_s = 3'd0;
    case (size_out)
      2'b00:   begin n_elem_s = 5'd4;  last_word_s = 3'd0; end
      2'b01:   begin n_elem_s = 5'd9;  last_word_s = 3'd2; end
      2'b10:   begin n_elem_s = 5'd16; last_word_s = 3'd3; end
      2'b11:   begin n_elem_s = 5'd25; last_word_s = 3'd6; end
      default: begin n_elem_s = 5'd4;  last_word_s = 3'd0; end
    endcase
  end

  // Next-state, word counter and matrix update logic.
  always_comb begin
    state_next_s = state_r;
    count_next_s = count_r;
    size_next_s  = size_out;
    m1_next_s    = matrix1_out;
    m2_next_s    = matrix2_out;
    case (state_r)
      IDLE: begin
        if (start) begin
          state_next_s = LOAD_M1;
          size_next_s  = size;
          m1_next_s    = 200'd0;
          m2_next_s    = 200'd0;
          count_next_s = 3'd0;
        end else begin
          state_next_s = IDLE;
        end
      end
      LOAD_M1: begin
        if (in_valid) begin
          m1_next_s = merge_word(matrix1_out, in_data, count_r, n_elem_s);
          if (count_r == last_word_s) begin
            count_next_s = 3'd0;
            state_next_s = LOAD_M2;
          end else begin
            count_next_s = count_r + 3'd1;
          end
        end else begin
          count_next_s = count_r;
        end
      end
      LOAD_M2: begin
        if (in_valid) begin
          m2_next_s = merge_word(matrix2_out, in_data, count_r, n_elem_s);
          if (count_r == last_word_s) begin
            count_next_s = 3'd0;
            state_next_s = DONE;
          end else begin
            count_next_s = count_r + 3'd1;
          end
        end else begin
          count_next_s = count_r;
        end
      end
      DONE: begin
        if (consume) begin
          state_next_s = IDLE;
        end else begin
          state_next_s = DONE;
        end
      end
      default: begin
        state_next_s = IDLE;
      end
    endcase
  end

  // State, datapath and registered status flags; reset wins over everything.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r      <= IDLE;
      count_r      <= 3'd0;
      size_out     <= 2'b00;
      matrix1_out  <= 200'd0;
      matrix2_out  <= 200'd0;
      in_ready     <= 1'b0;
      matrix_valid <= 1'b0;
      busy         <= 1'b0;
    end else begin
      state_r      <= state_next_s;
      count_r      <= count_next_s;
      size_out     <= size_next_s;
      matrix1_out  <= m1_next_s;
      matrix2_out  <= m2_next_s;
      in_ready     <= (state_next_s == LOAD_M1) || (state_next_s == LOAD_M2);
      matrix_valid <= (state_next_s == DONE);
      busy         <= (state_next_s != IDLE);
    end
  end

endmodule

// File: tb/tb_matrix_loader_hps.sv
// Scoreboard bench for matrix_loader_hps: expected matrices are queued when a
// load starts and a monitor compares them when matrix_valid rises.
module tb_matrix_loader_hps;

  typedef struct {
    logic [199:0] m1;
    logic [199:0] m2;
    logic [1:0]   sz;
  } exp_t;

  logic         clk = 1'b0;
  logic         reset, start, in_valid, consume;
  logic [1:0]   size;
  logic [31:0]  in_data;
  logic         in_ready, matrix_valid, busy;
  logic [199:0] matrix1_out, matrix2_out;
  logic [1:0]   size_out;

  exp_t exp_q[$];
  int   tests  = 0;
  int   failed = 0;
  logic prev_valid = 1'b0;

  matrix_loader_hps #(.DATA_W(32)) dut (
    .clk(clk), .reset(reset), .start(start), .size(size),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .matrix1_out(matrix1_out), .matrix2_out(matrix2_out),
    .size_out(size_out), .matrix_valid(matrix_valid),
    .consume(consume), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [199:0] act, input logic [199:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Monitor: on each rising matrix_valid, pop one expectation and compare.
  always @(negedge clk) begin
    exp_t e;
    if (matrix_valid && !prev_valid) begin
      if (exp_q.size() == 0) begin
        check("sb_unexpected_valid", 200'd1, 200'd0);
      end else begin
        e = exp_q.pop_front();
        check("sb_matrix1", matrix1_out, e.m1);
        check("sb_matrix2", matrix2_out, e.m2);
        check("sb_size", {198'd0, size_out}, {198'd0, e.sz});
      end
    end
    prev_valid <= matrix_valid;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input logic [1:0] sz);
    start = 1'b1; size = sz;
    tick();
    start = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w);
    in_valid = 1'b1; in_data = w;
    tick();
    in_valid = 1'b0; in_data = 32'hDEADBEEF;
  endtask

  task automatic push_exp(input logic [199:0] m1, input logic [199:0] m2, input logic [1:0] sz);
    exp_t e;
    e.m1 = m1; e.m2 = m2; e.sz = sz;
    exp_q.push_back(e);
  endtask

  // Called right after the last word: checks latency, then hands off with consume.
  task automatic handoff(input string name, input logic [199:0] m1, input logic [199:0] m2);
    check({name, "_valid_rise"}, {199'd0, matrix_valid}, 200'd1);
    consume = 1'b1;
    tick();
    consume = 1'b0;
    check({name, "_valid_drop"}, {199'd0, matrix_valid}, 200'd0);
    check({name, "_busy_idle"}, {199'd0, busy}, 200'd0);
    check({name, "_m1_hold"}, matrix1_out, m1);
    check({name, "_m2_hold"}, matrix2_out, m2);
  endtask

  initial begin
    logic [199:0] e1, e2;
    logic [31:0]  w5a [7];
    logic [31:0]  w5b [7];
    reset = 1'b1; start = 1'b0; size = 2'b00; in_data = 32'h0;
    in_valid = 1'b0; consume = 1'b0;
    tick(); tick();
    reset = 1'b0;
    check("reset_m1", matrix1_out, 200'd0);
    check("reset_m2", matrix2_out, 200'd0);
    check("reset_flags", {196'd0, in_ready, matrix_valid, busy, 1'b0}, 200'd0);

    // 4x4 load
    e1 = {128'h0102030405060708090A0B0C0D0E0F10, 72'h0};
    e2 = {128'h1112131415161718191A1B1C1D1E1F20, 72'h0};
    push_exp(e1, e2, 2'b10);
    do_start(2'b10);
    check("4x4_in_ready", {198'd0, in_ready, busy}, 200'd3);
    send_word(32'h01020304); send_word(32'h05060708);
    send_word(32'h090A0B0C); send_word(32'h0D0E0F10);
    send_word(32'h11121314); send_word(32'h15161718);
    send_word(32'h191A1B1C);
    check("4x4_not_yet_valid", {199'd0, matrix_valid}, 200'd0);
    send_word(32'h1D1E1F20);
    handoff("4x4", e1, e2);

    // 5x5 load; trailing BB/CC/DD bytes must be dropped
    w5a = '{32'h01020304, 32'h05060708, 32'h090A0B0C, 32'h0D0E0F10,
            32'h11121314, 32'h15161718, 32'hAABBCCDD};
    w5b = '{32'h21222324, 32'h25262728, 32'h292A2B2C, 32'h2D2E2F30,
            32'h31323334, 32'h35363738, 32'h39EEEEEE};
    e1 = {192'h0102030405060708090A0B0C0D0E0F101112131415161718, 8'hAA};
    e2 = {192'h2122232425262728292A2B2C2D2E2F303132333435363738, 8'h39};
    push_exp(e1, e2, 2'b11);
    do_start(2'b11);
    for (int i = 0; i < 7; i++) send_word(w5a[i]);
    for (int i = 0; i < 7; i++) send_word(w5b[i]);
    handoff("5x5", e1, e2);

    // 2x2 with backpressure: in_valid 1,0,0,1
    e1 = {32'hA1A2A3A4, 168'h0};
    e2 = {32'hB1B2B3B4, 168'h0};
    push_exp(e1, e2, 2'b00);
    do_start(2'b00);
    send_word(32'hA1A2A3A4);
    tick(); tick();
    check("bp_waiting", {198'd0, in_ready, matrix_valid}, 200'd2);
    send_word(32'hB1B2B3B4);
    handoff("bp", e1, e2);

    // 3x3 with consume during LOAD_M1 and start during LOAD_M2 (both ignored)
    e1 = {72'h010203040506070809, 128'h0};
    e2 = {72'h111213141516171819, 128'h0};
    push_exp(e1, e2, 2'b01);
    do_start(2'b01);
    send_word(32'h01020304);
    consume = 1'b1; tick(); consume = 1'b0;
    send_word(32'h05060708); send_word(32'h09AABBCC);
    send_word(32'h11121314);
    start = 1'b1; size = 2'b11; tick(); start = 1'b0;
    check("proto_size_kept", {198'd0, size_out}, {198'd0, 2'b01});
    send_word(32'h15161718); send_word(32'h19DDEEFF);
    handoff("proto", e1, e2);

    // 3x3 aborted by reset after two M1 words, then a clean 3x3 load
    do_start(2'b01);
    send_word(32'h55555555); send_word(32'h66666666);
    reset = 1'b1; tick(); reset = 1'b0;
    check("rst_mid_m1", matrix1_out, 200'd0);
    check("rst_mid_m2", matrix2_out, 200'd0);
    check("rst_mid_flags", {195'd0, size_out, in_ready, matrix_valid, busy}, 200'd0);
    e1 = {72'hC1C2C3C4C5C6C7C8C9, 128'h0};
    e2 = {72'hD1D2D3D4D5D6D7D8D9, 128'h0};
    push_exp(e1, e2, 2'b01);
    do_start(2'b01);
    send_word(32'hC1C2C3C4); send_word(32'hC5C6C7C8); send_word(32'hC9777777);
    send_word(32'hD1D2D3D4); send_word(32'hD5D6D7D8); send_word(32'hD9888888);
    handoff("post_rst", e1, e2);

    tick(); tick();
    check("sb_all_consumed", 200'(exp_q.size()), 200'd0);
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

// File: doc/matrix_loader_hps.md
MATRIX_LOADER_HPS -- requirements
Module: matrix_loader_hps

Interface
REQ-001 SHALL have parameter DATA_W, default 32, meaning HPS input word width in bits; only 32 is supported.
REQ-002 SHALL have port clk, input, 1, meaning the single system clock; all state changes on its rising edge.
REQ-003 SHALL have port reset, input, 1, meaning synchronous active-high reset.
REQ-004 SHALL have port start, input, 1, meaning a one-cycle request to begin loading a matrix pair.
REQ-005 SHALL have port size, input, 2, meaning matrix dimension code sampled with start: 00=2x2, 01=3x3, 10=4x4, 11=5x5.
REQ-006 SHALL have port in_data, input, 32, meaning four 8-bit elements with the first element in [31:24].
REQ-007 SHALL have port in_valid, input, 1, meaning in_data is valid this cycle.
REQ-008 SHALL have port in_ready, output, 1, meaning the block accepts in_data this cycle.
REQ-009 SHALL have port matrix1_out, output, 200, meaning matrix 1 packed contiguously, element 0 at [199:192].
REQ-010 SHALL have port matrix2_out, output, 200, meaning matrix 2 packed the same way as matrix 1.
REQ-011 SHALL have port size_out, output, 2, meaning the latched size code.
REQ-012 SHALL have port matrix_valid, output, 1, meaning the matrix outputs are complete and stable.
REQ-013 SHALL have port consume, input, 1, meaning a one-cycle acknowledge from the downstream reorganising stage.
REQ-014 SHALL have port busy, output, 1, meaning the FSM is not in IDLE.

Function
REQ-015 SHALL implement FSM states IDLE, LOAD_M1, LOAD_M2 and DONE.
REQ-016 IDLE -> LOAD_M1 SHALL occur on start=1; in the same edge, size SHALL be latched, both matrix registers SHALL be cleared to 0, and the word counter SHALL be set to 0.
REQ-017 start SHALL be ignored in every state except IDLE.
REQ-018 Element count N SHALL be 4/9/16/25 and words per matrix W SHALL be 1/3/4/7 for size codes 00/01/10/11.
REQ-019 A word SHALL be accepted only when in_valid and in_ready are both 1; in_ready SHALL be 1 exactly in LOAD_M1 and LOAD_M2.
REQ-020 Accepted word k (0-based) SHALL write byte j (j=0..3, byte 0 = in_data[31:24]) to element 4k+j, i.e. bits [199-8(4k+j) -: 8], only when 4k+j < N; bytes with index >= N SHALL be discarded.
REQ-021 Elements with index >= N SHALL remain 0.
REQ-022 When the accepted word has k = W-1, the counter SHALL return to 0 and the FSM SHALL go LOAD_M1 -> LOAD_M2 or LOAD_M2 -> DONE; otherwise the counter SHALL increment by 1.
REQ-023 Cycles with in_valid=0 SHALL hold the counter and the registers unchanged; there is no timeout.
REQ-024 matrix_valid SHALL be 1 exactly in DONE.
REQ-025 DONE -> IDLE SHALL occur on consume=1; consume SHALL be ignored in all other states.
REQ-026 matrix1_out, matrix2_out and size_out SHALL be registered and SHALL hold their values through DONE and IDLE until the next accepted start.
REQ-027 Latency SHALL be: matrix_valid rises on the edge that accepts the last word of matrix 2; minimum start-to-matrix_valid is 2W+1 edges.
REQ-028 busy SHALL be 0 in IDLE and 1 otherwise.

Reset
REQ-029 reset=1 SHALL force IDLE, counter=0, matrix1_out=0, matrix2_out=0, size_out=00, matrix_valid=0, in_ready=0 and busy=0 on the next edge, including mid-load.
REQ-030 reset SHALL take priority over start, in_valid and consume in the same cycle.

Verification
REQ-031 4x4 test: start with size=10, then M1 words 01020304, 05060708, 090A0B0C, 0D0E0F10 and M2 words 11121314..1D1E1F20 -> matrix1_out[199:72]=0102..10, [71:0]=0; matrix2_out likewise; matrix_valid=1 after the 8th accepted word.
REQ-032 5x5 test: 7 words per matrix, M1 last word AABBCCDD -> matrix1_out[7:0]=AA; BB, CC and DD are discarded; matrix_valid=1 after 14 words.
REQ-033 Backpressure test: size=00 with in_valid toggled 1,0,0,1 -> exactly 2 words accepted, DONE reached, no element skipped or duplicated.
REQ-034 Protocol test: start pulsed during LOAD_M2 and consume pulsed during LOAD_M1 -> no state, size or counter change.
REQ-035 Reset test: reset asserted after 2 accepted M1 words of a 3x3 load -> all outputs 0 on the next edge; a fresh 3x3 load then completes correctly with matrix1_out[127:0]=0.
REQ-036 Handoff test: consume=1 in DONE -> IDLE, matrix_valid=0, matrix1_out and matrix2_out unchanged.
